// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshakes on both sides and a bit-serial
// shift-add multiplier (ctrl=7) that stalls the input side while it runs.
module alu_pipe #(
  parameter int WIDTH      = 18,
  parameter bit SIGNED_CMP = 1'b1,
  parameter bit MUL_EN     = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] datA,
  input  logic [WIDTH-1:0] datB,
  input  logic [2:0]       ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             N,
  output logic             Z,
  output logic             C,
  output logic             V,
  output logic             AgtB
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, MUL} state_t;

  state_t             state_q, state_d;
  logic               valid_q, valid_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               n_q, n_d, z_q, z_d, c_q, c_d, v_q, v_d, agtb_q, agtb_d;
  logic               mulAgtb_q, mulAgtb_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic               accept;
  logic [WIDTH:0]     sum, diff;
  logic [WIDTH-1:0]   opRes;
  logic               opC, opV, cmpIn;

  assign in_ready = rst_n & (state_q == IDLE) & (~valid_q | out_ready);
  assign accept   = in_valid & in_ready;
  assign sum      = {1'b0, datA} + {1'b0, datB};
  assign diff     = {1'b0, datA} - {1'b0, datB};
  assign cmpIn    = SIGNED_CMP ? ($signed(datA) > $signed(datB)) : (datA > datB);

  // Single-cycle operations; the default arm is ctrl=7 with the multiplier disabled.
  always_comb begin
    opRes = '0;
    opC   = 1'b0;
    opV   = 1'b0;
    case (ctrl)
      3'd0: opRes = datA;
      3'd1: opRes = datB;
      3'd2: opRes = ~datA;
      3'd3: begin
        opRes = sum[WIDTH-1:0];
        opC   = sum[WIDTH];
        opV   = (datA[WIDTH-1] == datB[WIDTH-1]) & (sum[WIDTH-1] != datA[WIDTH-1]);
      end
      3'd4: begin
        opRes = diff[WIDTH-1:0];
        opC   = diff[WIDTH];
        opV   = (datA[WIDTH-1] != datB[WIDTH-1]) & (diff[WIDTH-1] != datA[WIDTH-1]);
      end
      3'd5: opRes = datA | datB;
      3'd6: opRes = datA & datB;
      default: opV = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    res_d     = res_q;
    n_d       = n_q;
    z_d       = z_q;
    c_d       = c_q;
    v_d       = v_q;
    agtb_d    = agtb_q;
    mulAgtb_d = mulAgtb_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;

    if (valid_q && out_ready) valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (ctrl == 3'd7 && MUL_EN) begin
            state_d   = MUL;
            mulAgtb_d = cmpIn;
            acc_d     = '0;
            mcand_d   = {{WIDTH{1'b0}}, datA};
            mplier_d  = datB;
            cnt_d     = '0;
          end else begin
            valid_d = 1'b1;
            res_d   = opRes;
            n_d     = opRes[WIDTH-1];
            z_d     = (opRes == '0);
            c_d     = opC;
            v_d     = opV;
            agtb_d  = cmpIn;
          end
        end
      end
      MUL: begin
        // WIDTH partial-product steps, then one extra edge to publish the product.
        if (cnt_q == CW'(WIDTH)) begin
          state_d = IDLE;
          valid_d = 1'b1;
          res_d   = acc_q[WIDTH-1:0];
          n_d     = acc_q[WIDTH-1];
          z_d     = (acc_q[WIDTH-1:0] == '0);
          c_d     = 1'b0;
          v_d     = |acc_q[2*WIDTH-1:WIDTH];
          agtb_d  = mulAgtb_q;
        end else begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      valid_q   <= 1'b0;
      res_q     <= '0;
      n_q       <= 1'b0;
      z_q       <= 1'b0;
      c_q       <= 1'b0;
      v_q       <= 1'b0;
      agtb_q    <= 1'b0;
      mulAgtb_q <= 1'b0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      res_q     <= res_d;
      n_q       <= n_d;
      z_q       <= z_d;
      c_q       <= c_d;
      v_q       <= v_d;
      agtb_q    <= agtb_d;
      mulAgtb_q <= mulAgtb_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
    end
  end

  assign out_valid = valid_q;
  assign alu_out   = res_q;
  assign N         = n_q;
  assign Z         = z_q;
  assign C         = c_q;
  assign V         = v_q;
  assign AgtB      = agtb_q;

endmodule
